ras_ctrl: RTL and testbench

//  Return-address-stack controller for the fetch/branch-status stage.
//  - Consumes call/return flags decoded per fetched instruction; pushes return

---
 rtl/ras_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ras_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ras_ctrl
// Brief    : Return-address stack with in-order branch checkpoints for flush
//            recovery. Optional macro RAS_CKPT_TOP_EN also saves/repairs the
//            top entry in each checkpoint.
// Revision : 1.0
// ============================================================================
`ifndef AddrWidth
`define AddrWidth 32
`endif

module ras_ctrl #(
    parameter int ADDR  = `AddrWidth,
    parameter int DEPTH = 8,
    parameter int CKPT  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_en,
    input  logic [ADDR-1:0]         push_addr,
    input  logic                    pop_en,
    output logic                    pop_valid,
    output logic [ADDR-1:0]         pop_target,
    input  logic                    ckpt_req,
    output logic                    ckpt_full,
    output logic [$clog2(CKPT)-1:0] ckpt_id,
    input  logic                    commit_en,
    input  logic                    flush_en,
    input  logic [$clog2(CKPT)-1:0] flush_id
);

    localparam int TW = $clog2(DEPTH);
    localparam int CW = TW + 1;
    localparam int IW = $clog2(CKPT);
    localparam int NW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [NW-1:0] CKPT_C  = NW'(CKPT);

    logic [ADDR-1:0] mem_q [DEPTH];
    logic [TW-1:0]   tos_q, tos_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop_valid_q, pop_valid_d;
    logic [ADDR-1:0] pop_target_q, pop_target_d;

    logic [TW-1:0]   slot_tos_q [CKPT];
    logic [CW-1:0]   slot_cnt_q [CKPT];
`ifdef RAS_CKPT_TOP_EN
    logic [ADDR-1:0] slot_top_q [CKPT];
    logic [ADDR-1:0] top_d;
`endif
    logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [NW-1:0]   cnt_q, cnt_d;

    logic            mem_we;
    logic [TW-1:0]   mem_wa;
    logic [ADDR-1:0] mem_wd;
    logic            ckpt_take;
    logic            commit_ok;
    logic [IW-1:0]   flush_off;

    assign ckpt_full  = (cnt_q == CKPT_C);
    assign ckpt_id    = tail_q;
    assign pop_valid  = pop_valid_q;
    assign pop_target = pop_target_q;

    // A flush squashes every same-cycle request, so they never reach the stack.
    assign ckpt_take = ckpt_req & ~ckpt_full & ~flush_en;
    assign commit_ok = commit_en & (cnt_q != '0);
    assign flush_off = flush_id - head_q;

    always_comb begin
        tos_d        = tos_q;
        count_d      = count_q;
        pop_valid_d  = 1'b0;
        pop_target_d = '0;
        if (flush_en) begin
            tos_d   = slot_tos_q[flush_id];
            count_d = slot_cnt_q[flush_id];
        end else if (push_en && pop_en) begin
            if (count_q != '0) begin
                pop_valid_d  = 1'b1;
                pop_target_d = mem_q[tos_q];
            end
        end else if (push_en) begin
            tos_d = tos_q + TW'(1);
            if (count_q != DEPTH_C) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_en && (count_q != '0)) begin
            pop_valid_d  = 1'b1;
            pop_target_d = mem_q[tos_q];
            tos_d        = tos_q - TW'(1);
            count_d      = count_q - CW'(1);
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = tos_q;
        mem_wd = push_addr;
        if (push_en && !flush_en) begin
            mem_we = 1'b1;
            mem_wa = pop_en ? tos_q : tos_q + TW'(1);
        end
`ifdef RAS_CKPT_TOP_EN
        if (flush_en) begin
            mem_we = 1'b1;
            mem_wa = slot_tos_q[flush_id];
            mem_wd = slot_top_q[flush_id];
        end
`endif
    end

`ifdef RAS_CKPT_TOP_EN
    // Top after this cycle's update: a push (alone or with a pop) lands there.
    assign top_d = push_en ? push_addr : mem_q[tos_d];
`endif

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_en) begin
            tail_d = flush_id + IW'(1);
            if (commit_en) begin
                head_d = head_q + IW'(1);
                cnt_d  = NW'(flush_off);
            end else begin
                cnt_d  = NW'(flush_off) + NW'(1);
            end
        end else begin
            if (ckpt_take) begin
                tail_d = tail_q + IW'(1);
            end
            if (commit_ok) begin
                head_d = head_q + IW'(1);
            end
            case ({ckpt_take, commit_ok})
                2'b10:   cnt_d = cnt_q + NW'(1);
                2'b01:   cnt_d = cnt_q - NW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q        <= '0;
            count_q      <= '0;
            pop_valid_q  <= 1'b0;
            pop_target_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
        end else begin
            tos_q        <= tos_d;
            count_q      <= count_d;
            pop_valid_q  <= pop_valid_d;
            pop_target_q <= pop_target_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
        if (ckpt_take) begin
            slot_tos_q[tail_q] <= tos_d;
            slot_cnt_q[tail_q] <= count_d;
`ifdef RAS_CKPT_TOP_EN
            slot_top_q[tail_q] <= top_d;
`endif
        end
    end

`ifndef SYNTHESIS
    a_flush_id_live: assert property (@(posedge clk) disable iff (reset)
        flush_en |-> (NW'(flush_off) < cnt_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_ctrl
// Brief    : Directed + random bench for ras_ctrl against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_ras_ctrl;

    localparam int ADDR  = 32;
    localparam int DEPTH = 8;
    localparam int CKPT  = 4;
    localparam int IW    = $clog2(CKPT);

    logic            clk = 1'b0;
    logic            reset;
    logic            push_en, pop_en, ckpt_req, commit_en, flush_en;
    logic [ADDR-1:0] push_addr;
    logic [IW-1:0]   flush_id;
    logic            pop_valid, ckpt_full;
    logic [ADDR-1:0] pop_target;
    logic [IW-1:0]   ckpt_id;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ras_ctrl #(.ADDR(ADDR), .DEPTH(DEPTH), .CKPT(CKPT)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_en    (push_en),
        .push_addr  (push_addr),
        .pop_en     (pop_en),
        .pop_valid  (pop_valid),
        .pop_target (pop_target),
        .ckpt_req   (ckpt_req),
        .ckpt_full  (ckpt_full),
        .ckpt_id    (ckpt_id),
        .commit_en  (commit_en),
        .flush_en   (flush_en),
        .flush_id   (flush_id)
    );

    // Reference: stack contents as an array, checkpoints as a queue of snapshots.
    typedef struct {
        int              id;
        int              tos;
        int              cnt;
        logic [ADDR-1:0] top;
    } ck_t;

    logic [ADDR-1:0] m_ent [DEPTH];
    int              m_tos, m_cnt, m_nid;
    ck_t             m_q[$];
    logic            exp_pv;
    logic [ADDR-1:0] exp_pt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_tos = 0; m_cnt = 0; m_nid = 0;
        m_q.delete();
        exp_pv = 1'b0; exp_pt = '0;
    endfunction

    function automatic void model_step(input logic p, input logic [ADDR-1:0] a, input logic o,
                                       input logic cr, input logic cm, input logic fl,
                                       input int fid);
        bit full_before;
        int k;
        exp_pv = 1'b0;
        exp_pt = '0;
        if (fl) begin
            k = 0;
            foreach (m_q[i]) if (m_q[i].id == fid) k = i;
            m_tos = m_q[k].tos;
            m_cnt = m_q[k].cnt;
`ifdef RAS_CKPT_TOP_EN
            m_ent[m_tos] = m_q[k].top;
`endif
            while (m_q.size() > k + 1) void'(m_q.pop_back());
            m_nid = (fid + 1) % CKPT;
            if (cm) void'(m_q.pop_front());
        end else begin
            if (p && o) begin
                if (m_cnt > 0) begin
                    exp_pv = 1'b1;
                    exp_pt = m_ent[m_tos];
                end
                m_ent[m_tos] = a;
            end else if (p) begin
                m_tos = (m_tos + 1) % DEPTH;
                m_ent[m_tos] = a;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (o && m_cnt > 0) begin
                exp_pv = 1'b1;
                exp_pt = m_ent[m_tos];
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
            full_before = (m_q.size() == CKPT);
            if (cm && m_q.size() > 0) void'(m_q.pop_front());
            if (cr && !full_before) begin
                m_q.push_back('{id: m_nid, tos: m_tos, cnt: m_cnt, top: m_ent[m_tos]});
                m_nid = (m_nid + 1) % CKPT;
            end
        end
    endfunction

    // Called at a negedge: drive, step across one posedge, check at next negedge.
    task automatic cyc(input logic p, input logic [ADDR-1:0] a, input logic o,
                       input logic cr, input logic cm, input logic fl, input int fid);
        push_en = p; push_addr = a; pop_en = o;
        ckpt_req = cr; commit_en = cm; flush_en = fl; flush_id = IW'(fid);
        #1;
        if (cr && !fl && m_q.size() < CKPT) check_eq("ckpt_id", 64'(ckpt_id), 64'(m_nid));
        @(posedge clk);
        model_step(p, a, o, cr, cm, fl, fid);
        @(negedge clk);
        check_eq("pop_valid", 64'(pop_valid), 64'(exp_pv));
        check_eq("pop_target", 64'(pop_target), 64'(exp_pt));
        check_eq("ckpt_full", 64'(ckpt_full), 64'(m_q.size() == CKPT));
        push_en = 0; pop_en = 0; ckpt_req = 0; commit_en = 0; flush_en = 0;
    endtask

    task automatic push(input logic [ADDR-1:0] a); cyc(1, a, 0, 0, 0, 0, 0); endtask
    task automatic pop();                          cyc(0, '0, 1, 0, 0, 0, 0); endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_eq("rst_pop_valid", 64'(pop_valid), 64'(0));
        check_eq("rst_pop_target", 64'(pop_target), 64'(0));
        check_eq("rst_ckpt_full", 64'(ckpt_full), 64'(0));
        check_eq("rst_ckpt_id", 64'(ckpt_id), 64'(0));
        reset = 1'b0;
    endtask

    initial begin
        push_en = 0; pop_en = 0; ckpt_req = 0; commit_en = 0; flush_en = 0;
        push_addr = '0; flush_id = '0;
        foreach (m_ent[i]) m_ent[i] = '0;
        do_reset();

        // LIFO order, then underflow
        push('hA); push('hB); push('hC);
        pop(); check_eq("t1_first", 64'(pop_target), 64'h0C);
        pop(); pop(); pop();
        check_eq("t1_empty", 64'(pop_valid), 64'(0));

        // Overflow wraps over the oldest entries
        for (int i = 1; i <= DEPTH + 2; i++) push(ADDR'(i));
        pop(); check_eq("t2_first", 64'(pop_target), 64'(DEPTH + 2));
        for (int i = 1; i < DEPTH; i++) pop();
        check_eq("t2_last", 64'(pop_target), 64'(3));
        pop();

        // Same-cycle push+pop replaces the top
        push('hA);
        cyc(1, 'hB, 1, 0, 0, 0, 0);
        check_eq("t3_swap", 64'(pop_target), 64'h0A);
        pop(); pop();

        // Checkpoint recovery across wrong-path push/pop
        push('hA); cyc(0, '0, 0, 1, 0, 0, 0);
        push('h58); pop();
        cyc(0, '0, 0, 0, 0, 1, 0);
        pop(); check_eq("t4_restore", 64'(pop_target), 64'h0A);
        pop();
        cyc(0, '0, 0, 0, 1, 0, 0);
        push('hA); cyc(0, '0, 0, 1, 0, 0, 0);
        pop(); push('h59);
        cyc(0, '0, 0, 0, 0, 1, m_q[0].id);
        pop(); pop();
        while (m_q.size() > 0) cyc(0, '0, 0, 0, 1, 0, 0);

        // Checkpoint capacity
        do_reset();
        for (int i = 0; i < CKPT + 1; i++) cyc(0, '0, 0, 1, 0, 0, 0);
        cyc(0, '0, 0, 0, 1, 0, 0);
        cyc(0, '0, 0, 1, 0, 0, 0);
        while (m_q.size() > 0) cyc(0, '0, 0, 0, 1, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic p, o, cr, cm, fl;
            int fid;
            p  = ($urandom_range(0, 99) < 40);
            o  = ($urandom_range(0, 99) < 40);
            cr = ($urandom_range(0, 99) < 30);
            cm = ($urandom_range(0, 99) < 20);
            fl = (m_q.size() > 0) && ($urandom_range(0, 99) < 8);
            fid = fl ? m_q[$urandom_range(0, m_q.size() - 1)].id : 0;
            cyc(p, ADDR'($urandom), o, cr, cm, fl, fid);
        end

        // Reset landing on a pop cycle with a full checkpoint FIFO
        while (m_q.size() < CKPT) cyc(0, '0, 0, 1, 0, 0, 0);
        push('h77);
        pop_en = 1'b1;
        reset  = 1'b1;
        #1;
        check_eq("t6_async_full", 64'(ckpt_full), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_pop_valid", 64'(pop_valid), 64'(0));
        check_eq("t6_ckpt_full", 64'(ckpt_full), 64'(0));
        pop_en = 1'b0;
        reset  = 1'b0;
        model_reset();
        pop();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
